jpeg_dezigzag_dequant: RTL and testbench

Decoder-side counterpart of the encoder's quantize and zigzag stages. It accepts one quantized coefficient per cycle in zigzag order and multiplies each by the selected luma or chroma quantization entry. Results are stored in natural row-major order in a ping-pong buffer, and the block then streams 8-coefficient rows to the IDCT. End-of-block (EOB) shortening of a block is supported by zero-filling the remainder.

---
 rtl/jpeg_dezigzag_dequant.sv | 143 ++++++++++++++
 tb/tb_jpeg_dezigzag_dequant.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_dezigzag_dequant.sv
// Decoder-side dequantizer and de-zigzag: one zigzag-ordered coefficient per cycle into a
// ping-pong bank, then 8-coefficient natural-order rows streamed out to the IDCT.
module jpeg_dezigzag_dequant #(
    parameter int COEF_W = 10,
    parameter int OUT_W  = 12,
    parameter int Q_W    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     qt_wr_en,
    input  logic                     qt_wr_sel,
    input  logic [5:0]               qt_wr_addr,
    input  logic [Q_W-1:0]           qt_wr_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] in_coef,
    input  logic                     in_last,
    input  logic                     in_is_luminance,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*OUT_W-1:0]       out_row,
    output logic [2:0]               out_row_idx,
    output logic                     out_last,
    output logic                     err_len
);
    localparam int PW = COEF_W + Q_W + 1;
    localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    // Zigzag position k -> natural row-major index n
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [Q_W-1:0]          qt   [2][64];
    logic signed [OUT_W-1:0] bank [2][64];
    logic [63:0]             mask [2];
    logic [1:0]              full;
    logic                    wb;
    logic                    rb;
    logic [5:0]              k;
    logic [2:0]              row;
    logic                    chroma_blk;
    logic                    err_q;

    logic                    accept;
    logic                    close;
    logic                    release_bank;
    logic [5:0]              nat;
    logic                    tsel;
    logic signed [PW-1:0]    prod;
    logic signed [OUT_W-1:0] sat;
    logic [5:0]              rd_idx;

    assign in_ready     = !full[wb] && !reset;
    assign accept       = in_valid && in_ready;
    assign close        = accept && (in_last || k == 6'd63);
    assign out_valid    = full[rb] && !reset;
    assign out_row_idx  = reset ? 3'd0 : row;
    assign out_last     = out_valid && row == 3'd7;
    assign err_len      = err_q && !reset;
    assign release_bank = out_valid && out_ready && row == 3'd7;
    assign nat          = ZZ[k];
    // The block's table is chosen at k=0; later coefficients use the latched choice.
    assign tsel         = (k == 6'd0) ? !in_is_luminance : chroma_blk;

    always_comb begin
        prod = $signed(in_coef) * $signed({1'b0, qt[tsel][nat]});
        if (prod > SAT_MAX)
            sat = SAT_MAX[OUT_W-1:0];
        else if (prod < SAT_MIN)
            sat = SAT_MIN[OUT_W-1:0];
        else
            sat = prod[OUT_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int t = 0; t < 2; t++)
                for (int i = 0; i < 64; i++)
                    qt[t][i] <= Q_W'(1);
        end else if (qt_wr_en) begin
            qt[qt_wr_sel][qt_wr_addr] <= (qt_wr_data == '0) ? Q_W'(1) : qt_wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (accept)
            bank[wb][nat] <= sat;
    end

    // A releasing bank is always the one not being written, so the mask updates never collide.
    always_ff @(posedge clock) begin
        if (reset) begin
            full       <= 2'b00;
            wb         <= 1'b0;
            rb         <= 1'b0;
            k          <= 6'd0;
            row        <= 3'd0;
            chroma_blk <= 1'b0;
            err_q      <= 1'b0;
            mask[0]    <= '0;
            mask[1]    <= '0;
        end else begin
            err_q <= accept && k == 6'd63 && !in_last;
            if (accept) begin
                mask[wb][nat] <= 1'b1;
                if (k == 6'd0)
                    chroma_blk <= !in_is_luminance;
                k <= close ? 6'd0 : k + 6'd1;
                if (close) begin
                    full[wb] <= 1'b1;
                    wb       <= !wb;
                end
            end
            if (out_valid && out_ready)
                row <= row + 3'd1;
            if (release_bank) begin
                full[rb] <= 1'b0;
                mask[rb] <= '0;
                rb       <= !rb;
            end
        end
    end

    // Unwritten entries read as zero, giving EOB zero-fill for free.
    always_comb begin
        out_row = '0;
        rd_idx  = '0;
        for (int c = 0; c < 8; c++) begin
            rd_idx = {row, 3'(c)};
            if (mask[rb][rd_idx])
                out_row[OUT_W*c +: OUT_W] = bank[rb][rd_idx];
        end
    end
endmodule

// File: tb/tb_jpeg_dezigzag_dequant.sv
// Directed bench for jpeg_dezigzag_dequant: hand-computed rows for pass-through, dequant,
// saturation, table select, write hazard, ping-pong backpressure, length error and reset.
module tb_jpeg_dezigzag_dequant;
    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              qt_wr_en = 1'b0;
    logic              qt_wr_sel = 1'b0;
    logic [5:0]        qt_wr_addr = '0;
    logic [7:0]        qt_wr_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [9:0] in_coef = '0;
    logic              in_last = 1'b0;
    logic              in_is_luminance = 1'b1;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [95:0]       out_row;
    logic [2:0]        out_row_idx;
    logic              out_last;
    logic              err_len;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_send_acc = 0;
    int last_row_acc = 0;
    int b1r7 = 0;
    int b3acc = 0;
    int exp_mat [64];

    // Natural-order matrix of zigzag positions: entry n holds the k that lands there.
    int pt [64] = '{
         0,  1,  5,  6, 14, 15, 27, 28,
         2,  4,  7, 13, 16, 26, 29, 42,
         3,  8, 12, 17, 25, 30, 41, 43,
         9, 11, 18, 24, 31, 40, 44, 53,
        10, 19, 23, 32, 39, 45, 52, 54,
        20, 22, 33, 38, 46, 51, 55, 60,
        21, 34, 37, 47, 50, 56, 59, 61,
        35, 36, 48, 49, 57, 58, 62, 63
    };

    jpeg_dezigzag_dequant #(.COEF_W(10), .OUT_W(12), .Q_W(8)) dut (
        .clock(clock), .reset(reset),
        .qt_wr_en(qt_wr_en), .qt_wr_sel(qt_wr_sel), .qt_wr_addr(qt_wr_addr), .qt_wr_data(qt_wr_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef), .in_last(in_last),
        .in_is_luminance(in_is_luminance),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_row_idx(out_row_idx), .out_last(out_last), .err_len(err_len)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] row_of(input int r);
        logic [95:0] v;
        for (int c = 0; c < 8; c++) v[12*c +: 12] = 12'(exp_mat[r*8+c]);
        return v;
    endfunction

    task automatic clear_exp();
        for (int i = 0; i < 64; i++) exp_mat[i] = 0;
    endtask

    task automatic qt_write(input logic sel, input int addr, input int data);
        qt_wr_en = 1'b1; qt_wr_sel = sel; qt_wr_addr = 6'(addr); qt_wr_data = 8'(data);
        @(negedge clock);
        qt_wr_en = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input int coef, input logic last, input logic lum);
        int g = 0;
        in_valid = 1'b1; in_coef = 10'(coef); in_last = last; in_is_luminance = lum;
        while (!in_ready && g < 200) begin
            @(negedge clock);
            g++;
        end
        check("send ready", 96'(in_ready), 96'(1));
        last_send_acc = cyc + 1;
        @(negedge clock);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic get_row(input int r, input string tag);
        int g = 0;
        out_ready = 1'b1;
        while (!out_valid && g < 200) begin
            @(negedge clock);
            g++;
        end
        check({tag, " valid"}, 96'(out_valid), 96'(1));
        check({tag, " row"}, out_row, row_of(r));
        check({tag, " idx"}, 96'(out_row_idx), 96'(r));
        check({tag, " last"}, 96'(out_last), 96'(r == 7));
        last_row_acc = cyc + 1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic read_block(input string tag);
        for (int r = 0; r < 8; r++) get_row(r, $sformatf("%s r%0d", tag, r));
    endtask

    initial begin
        // reset state
        @(negedge clock);
        @(negedge clock);
        check("rst in_ready", 96'(in_ready), 96'(0));
        check("rst out_valid", 96'(out_valid), 96'(0));
        check("rst idx", 96'(out_row_idx), 96'(0));
        check("rst last", 96'(out_last), 96'(0));
        check("rst err", 96'(err_len), 96'(0));
        reset = 1'b0;
        @(negedge clock);
        check("post rst in_ready", 96'(in_ready), 96'(1));
        check("post rst out_valid", 96'(out_valid), 96'(0));

        // pass-through: coef = k, tables all 1
        for (int k = 0; k < 64; k++) send(k, k == 63, 1'b1);
        check("pt err_len", 96'(err_len), 96'(0));
        check("pt latency", 96'(out_valid), 96'(1));
        for (int i = 0; i < 64; i++) exp_mat[i] = pt[i];
        read_block("pt");
        check("pt drained", 96'(out_valid), 96'(0));

        // luma all 16, EOB at k=0
        for (int i = 0; i < 64; i++) qt_write(1'b0, i, 16);
        send(-100, 1'b1, 1'b1);
        clear_exp(); exp_mat[0] = -1600;
        read_block("dq");

        // saturation both directions
        send(200, 1'b0, 1'b1);
        send(-200, 1'b1, 1'b1);
        clear_exp(); exp_mat[0] = 2047; exp_mat[1] = -2048;
        read_block("sat");

        // table select latched at k=0: chroma q0=3, luma q0=5, chroma q1 still 1
        qt_write(1'b1, 0, 3);
        qt_write(1'b0, 0, 5);
        send(7, 1'b0, 1'b0);
        send(2, 1'b1, 1'b1);
        clear_exp(); exp_mat[0] = 21; exp_mat[1] = 2;
        read_block("tsel");

        // zero write stored as 1; write coincident with k=0 acceptance uses old value
        qt_write(1'b0, 1, 0);
        qt_wr_en = 1'b1; qt_wr_sel = 1'b0; qt_wr_addr = 6'd0; qt_wr_data = 8'd9;
        send(4, 1'b1, 1'b1);
        qt_wr_en = 1'b0;
        clear_exp(); exp_mat[0] = 20;
        read_block("hz old");
        send(4, 1'b0, 1'b1);
        send(5, 1'b1, 1'b1);
        clear_exp(); exp_mat[0] = 36; exp_mat[1] = 5;
        read_block("hz new");

        // ping-pong backpressure
        qt_write(1'b0, 0, 1);
        out_ready = 1'b0;
        send(1, 1'b1, 1'b1);
        send(2, 1'b1, 1'b1);
        check("pp both full", 96'(in_ready), 96'(0));
        clear_exp(); exp_mat[0] = 1;
        for (int s = 0; s < 3; s++) begin
            check("pp stall row", out_row, row_of(0));
            check("pp stall idx", 96'(out_row_idx), 96'(0));
            @(negedge clock);
        end
        fork
            begin
                send(3, 1'b1, 1'b1);
                b3acc = last_send_acc;
            end
            begin
                clear_exp(); exp_mat[0] = 1;
                read_block("pp b1");
                b1r7 = last_row_acc;
                clear_exp(); exp_mat[0] = 2;
                read_block("pp b2");
            end
        join
        check("pp b3 start", 96'(b3acc), 96'(b1r7 + 1));
        clear_exp(); exp_mat[0] = 3;
        read_block("pp b3");

        // length error, chroma (q0=3, others 1)
        for (int k = 0; k < 64; k++) send(k, 1'b0, 1'b0);
        check("len err pulse", 96'(err_len), 96'(1));
        send(77, 1'b1, 1'b0);
        check("len err once", 96'(err_len), 96'(0));
        for (int i = 0; i < 64; i++) exp_mat[i] = pt[i];
        read_block("len");
        clear_exp(); exp_mat[0] = 231;
        read_block("len next");

        // reset with a full bank draining and a partial block
        send(5, 1'b1, 1'b1);
        for (int k = 0; k < 30; k++) send(100 + k, 1'b0, 1'b1);
        clear_exp(); exp_mat[0] = 5;
        get_row(0, "mr r0");
        reset = 1'b1;
        @(negedge clock);
        check("mr out_valid", 96'(out_valid), 96'(0));
        check("mr in_ready", 96'(in_ready), 96'(0));
        reset = 1'b0;
        @(negedge clock);
        check("mr after valid", 96'(out_valid), 96'(0));
        check("mr after ready", 96'(in_ready), 96'(1));
        send(50, 1'b0, 1'b1);
        send(51, 1'b0, 1'b1);
        send(52, 1'b1, 1'b1);
        clear_exp(); exp_mat[0] = 50; exp_mat[1] = 51; exp_mat[8] = 52;
        read_block("mr fresh");
        check("mr empty", 96'(out_valid), 96'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
